// File: rtl/core_inst_sequencer.sv
// Instruction sequencer for core: emits the 40-bit inst word for one tile
// (FEED -> SHIFT -> DRAIN -> DONE) in OS or WS mode, honouring l0/ififo backpressure.
module core_inst_sequencer #(
  parameter int unsigned ROW       = 8,
  parameter int unsigned LEN_BW    = 8,
  parameter logic [7:0]  ACT_BASE  = 8'h00,
  parameter logic [7:0]  WGT_BASE  = 8'h80,
  parameter int unsigned CTRL_DLY  = 3,
  parameter int unsigned SHIFT_CYC = 2 * ROW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              os_mode,
  input  logic [LEN_BW-1:0] len,
  input  logic              l0_ready,
  input  logic              ififo_ready,
  input  logic              ofifo_valid,
  output logic [39:0]       inst,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SH_W = $clog2(SHIFT_CYC + 1);
  localparam int unsigned DR_W = $clog2(ROW + 1);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [LEN_BW-1:0] r_k, r_len;
  logic              r_os;
  logic [SH_W-1:0]   r_shift_cnt;
  logic [DR_W-1:0]   r_drain_cnt;

  logic              r_cen0, r_cen1;
  logic [7:0]        r_a0, r_a1;
  logic              r_l0_wr, r_l0_rd, r_ififo_wr, r_ififo_rd, r_ofifo_rd;
  logic              r_busy, r_done;
  logic [2:0]        r_ctrl [CTRL_DLY];

  logic              w_issue, w_last_issue, w_rd;
  logic [2:0]        w_ctrl;

  assign w_last_issue = (r_k == r_len - LEN_BW'(1));

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_rd        = 1'b0;
    w_ctrl      = 3'b000;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (len == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        w_ctrl  = {r_os, 1'b1, 1'b0};
        w_issue = l0_ready & ififo_ready;
        if (w_issue && w_last_issue) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_ctrl = {r_os, 1'b0, 1'b1};
        if (r_shift_cnt == SH_W'(SHIFT_CYC - 1)) w_state_nxt = r_os ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        w_rd = ofifo_valid;
        if (ofifo_valid && (r_drain_cnt == DR_W'(ROW - 1))) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, tile parameters and phase counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_len       <= '0;
      r_os        <= 1'b0;
      r_shift_cnt <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      if (r_state == S_IDLE && start) begin
        r_k   <= '0;
        r_len <= len;
        r_os  <= os_mode;
      end else if (w_issue) begin
        r_k <= r_k + LEN_BW'(1);
      end
      r_shift_cnt <= (r_state == S_SHIFT) ? r_shift_cnt + SH_W'(1) : '0;
      if (r_state != S_DRAIN) r_drain_cnt <= '0;
      else if (w_rd)          r_drain_cnt <= r_drain_cnt + DR_W'(1);
    end
  end

  // Memory strobes/addresses and the SRAM-latency fifo strobe tails
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cen0     <= 1'b1;
      r_cen1     <= 1'b1;
      r_a0       <= '0;
      r_a1       <= '0;
      r_l0_wr    <= 1'b0;
      r_l0_rd    <= 1'b0;
      r_ififo_wr <= 1'b0;
      r_ififo_rd <= 1'b0;
      r_ofifo_rd <= 1'b0;
    end else begin
      r_cen0 <= ~w_issue;
      r_cen1 <= ~(w_issue & r_os);
      if (w_issue) begin
        r_a0 <= ACT_BASE + 8'(r_k);
        if (r_os) r_a1 <= WGT_BASE + 8'(r_k);
      end
      r_l0_wr    <= ~r_cen0;
      r_l0_rd    <= r_l0_wr;
      r_ififo_wr <= ~r_cen1;
      r_ififo_rd <= r_ififo_wr;
      r_ofifo_rd <= w_rd;
    end
  end

  // mode/execute/load delay line; the last stage drives inst directly
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(CTRL_DLY); i++) r_ctrl[i] <= 3'b000;
    end else begin
      r_ctrl[0] <= w_ctrl;
      for (int i = 1; i < int'(CTRL_DLY); i++) r_ctrl[i] <= r_ctrl[i-1];
    end
  end

  assign inst = {1'b0, 1'b0, 1'b1, 1'b1, 9'd0,
                 r_cen1, r_a1, r_cen0, 1'b1, r_a0,
                 r_ofifo_rd, r_ififo_wr, r_ififo_rd, r_l0_rd, r_l0_wr,
                 r_ctrl[CTRL_DLY-1]};
  assign busy = r_busy;
  assign done = r_done;

endmodule
